// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch/data) and memory-side signals around mem_port_arbiter.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;

    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        d_stall;

    logic        err;

    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall, err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall, err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between instruction fetch and MEM-stage data for one
// 64-bit memory port: data has priority, fetch wins after STARVE_MAX lost rounds.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    mem_port_arbiter_if.slave io_bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        D_WAIT,
        RESP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_done;
    logic            w_timeout;
    logic [SW-1:0]   r_starve_cnt;
    logic [WW-1:0]   r_wait_cnt;
    logic            r_bit2;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [63:0]     r_mem_addr;
    logic [63:0]     r_mem_wdata;
    logic [31:0]     r_if_rdata;
    logic [63:0]     r_d_rdata;
    logic            r_if_valid;
    logic            r_d_valid;
    logic            r_err;
    logic            w_unused;

    assign w_unused = &{1'b0, io_bus.if_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The WAIT state itself records which requester owns the in-flight access.
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.d_req && (!io_bus.if_req || r_starve_cnt < SW'(STARVE_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = D_WAIT;
                end else if (io_bus.if_req) begin
                    w_grant_i    = 1'b1;
                    w_next_state = IF_WAIT;
                end
            end
            IF_WAIT, D_WAIT: begin
                if (io_bus.mem_ready) begin
                    w_done       = 1'b1;
                    w_next_state = RESP;
                end else if (r_wait_cnt == WW'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_bit2       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;

            if (w_grant_d) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= io_bus.d_we;
                r_mem_addr  <= io_bus.d_addr;
                r_mem_wdata <= io_bus.d_wdata;
                r_wait_cnt  <= '0;
                if (io_bus.if_req && r_starve_cnt != SW'(STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            end

            if (w_grant_i) begin
                r_mem_en     <= 1'b1;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= {io_bus.if_addr[63:3], 3'b000};
                r_bit2       <= io_bus.if_addr[2];
                r_wait_cnt   <= '0;
                r_starve_cnt <= '0;
            end

            if (r_state == IF_WAIT || r_state == D_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end

            // A timed-out access still completes, but with zeroed read data and err set.
            if (w_done || w_timeout) begin
                r_mem_en <= 1'b0;
                r_err    <= w_timeout;
                if (r_state == IF_WAIT) begin
                    r_if_valid <= 1'b1;
                    if (w_timeout) begin
                        r_if_rdata <= '0;
                    end else begin
                        r_if_rdata <= r_bit2 ? io_bus.mem_rdata[63:32] : io_bus.mem_rdata[31:0];
                    end
                end else begin
                    r_d_valid <= 1'b1;
                    if (w_timeout) begin
                        r_d_rdata <= '0;
                    end else if (!r_mem_we) begin
                        r_d_rdata <= io_bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign io_bus.mem_en    = r_mem_en;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.if_rdata  = r_if_rdata;
    assign io_bus.if_valid  = r_if_valid;
    assign io_bus.d_rdata   = r_d_rdata;
    assign io_bus.d_valid   = r_d_valid;
    assign io_bus.err       = r_err;
    assign io_bus.if_stall  = io_bus.if_req & ~r_if_valid;
    assign io_bus.d_stall   = io_bus.d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: a transaction-level model predicts
// who is granted, what reaches the memory, and what each requester gets back.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rstN),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Requester-side state: a pending request persists until it has been served.
    bit          ifPending = 1'b0;
    logic [63:0] ifAddr    = '0;
    bit          dPending  = 1'b0;
    bit          dWe       = 1'b0;
    logic [63:0] dAddr     = '0;
    logic [63:0] dWdata    = '0;

    // Reference model state.
    int          starveCnt  = 0;
    logic [31:0] expIfRdata = '0;
    logic [63:0] expDRdata  = '0;
    bit          lastGrantD = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "MemEn"},   64'(bus.mem_en),    64'(0));
        checkOutput({tag, "MemWe"},   64'(bus.mem_we),    64'(0));
        checkOutput({tag, "MemAddr"}, bus.mem_addr,       64'(0));
        checkOutput({tag, "MemWdata"}, bus.mem_wdata,     64'(0));
        checkOutput({tag, "IfRdata"}, 64'(bus.if_rdata),  64'(0));
        checkOutput({tag, "DRdata"},  bus.d_rdata,        64'(0));
        checkOutput({tag, "Valids"},  64'({bus.if_valid, bus.d_valid, bus.err}), 64'(0));
    endtask

    task automatic refillRequests(input int pctIf, input int pctD);
        if (!ifPending && $urandom_range(0, 99) < pctIf) begin
            ifPending = 1'b1;
            ifAddr    = {$urandom, $urandom} & ~64'h3;
        end
        if (!dPending && $urandom_range(0, 99) < pctD) begin
            dPending = 1'b1;
            dWe      = 1'($urandom_range(0, 1));
            dAddr    = {$urandom, $urandom};
            dWdata   = {$urandom, $urandom};
        end
    endtask

    // One arbitration round starting in IDLE; returns one cycle after RESP (back in IDLE).
    task automatic applyStimulus(input int latency, input logic [63:0] word, input bit strayReady,
                                 input bit resetMid, input bit dropReq);
        bit          grantD;
        bit          timedOut;
        logic [63:0] expAddr;

        bus.if_req    = ifPending;
        bus.if_addr   = ifAddr;
        bus.d_req     = dPending;
        bus.d_we      = dWe;
        bus.d_addr    = dAddr;
        bus.d_wdata   = dWdata;
        bus.mem_ready = strayReady;
        bus.mem_rdata = {$urandom, $urandom};
        #1;
        checkOutput("idleIfStall", 64'(bus.if_stall), 64'(ifPending));
        checkOutput("idleDStall",  64'(bus.d_stall),  64'(dPending));

        if (!ifPending && !dPending) begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            checkOutput("noReqMemEn", 64'(bus.mem_en), 64'(0));
            checkOutput("noReqValid", 64'({bus.if_valid, bus.d_valid, bus.err}), 64'(0));
            return;
        end

        grantD = dPending && (!ifPending || starveCnt < STARVE_MAX);
        if (grantD) begin
            if (ifPending && starveCnt < STARVE_MAX) starveCnt++;
        end else begin
            starveCnt = 0;
        end
        expAddr = grantD ? dAddr : (ifAddr & ~64'h7);

        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        timedOut      = 1'b0;

        for (int j = 0; j < TIMEOUT; j++) begin
            checkOutput("waitMemEn",   64'(bus.mem_en), 64'(1));
            checkOutput("waitMemAddr", bus.mem_addr,    expAddr);
            checkOutput("waitMemWe",   64'(bus.mem_we), 64'(grantD && dWe));
            if (grantD) checkOutput("waitMemWdata", bus.mem_wdata, dWdata);
            checkOutput("waitIfStall", 64'(bus.if_stall), 64'(bus.if_req));
            checkOutput("waitDStall",  64'(bus.d_stall),  64'(bus.d_req));
            checkOutput("waitValid",   64'({bus.if_valid, bus.d_valid, bus.err}), 64'(0));

            if (resetMid) begin
                rstN          = 1'b0;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = word;
                @(posedge clk);
                #1;
                checkAllZero("midRst");
                rstN          = 1'b1;
                bus.mem_ready = 1'b0;
                starveCnt     = 0;
                expIfRdata    = '0;
                expDRdata     = '0;
                return;
            end

            if (dropReq) begin
                if (grantD) bus.d_req = 1'b0;
                else        bus.if_req = 1'b0;
            end
            bus.mem_ready = (j == latency);
            bus.mem_rdata = (j == latency) ? word : {$urandom, $urandom};
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            if (j == latency) break;
            if (j == TIMEOUT - 1) timedOut = 1'b1;
        end

        if (grantD) begin
            if (timedOut)  expDRdata = '0;
            else if (!dWe) expDRdata = word;
        end else begin
            expIfRdata = timedOut ? 32'h0 : (ifAddr[2] ? word[63:32] : word[31:0]);
        end

        checkOutput("respMemEn",   64'(bus.mem_en),   64'(0));
        checkOutput("respIfValid", 64'(bus.if_valid), 64'(!grantD));
        checkOutput("respDValid",  64'(bus.d_valid),  64'(grantD));
        checkOutput("respErr",     64'(bus.err),      64'(timedOut));
        checkOutput("respIfRdata", 64'(bus.if_rdata), 64'(expIfRdata));
        checkOutput("respDRdata",  bus.d_rdata,       expDRdata);
        checkOutput("respIfStall", 64'(bus.if_stall), 64'(bus.if_req && grantD));
        checkOutput("respDStall",  64'(bus.d_stall),  64'(bus.d_req && !grantD));
        lastGrantD = bus.d_valid;

        if (grantD) dPending = 1'b0;
        else        ifPending = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("postRespValid", 64'({bus.if_valid, bus.d_valid, bus.err}), 64'(0));
        checkOutput("postRespMemEn", 64'(bus.mem_en), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit expectD [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int latency;
        int pick;

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rstN = 1'b1;

        $display("[TB] single load");
        dPending = 1'b1; dWe = 1'b0; dAddr = 64'h40; dWdata = '0;
        applyStimulus(0, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, 1'b0);

        $display("[TB] fetch halves");
        ifPending = 1'b1; ifAddr = 64'h104;
        applyStimulus(0, 64'h11111111_22222222, 1'b0, 1'b0, 1'b0);
        checkOutput("fetchUpper", 64'(bus.if_rdata), 64'h11111111);
        ifPending = 1'b1; ifAddr = 64'h100;
        applyStimulus(1, 64'h11111111_22222222, 1'b0, 1'b0, 1'b0);
        checkOutput("fetchLower", 64'(bus.if_rdata), 64'h22222222);

        $display("[TB] contention");
        for (int i = 0; i < 10; i++) begin
            ifPending = 1'b1;
            if (!dPending) begin
                dPending = 1'b1; dWe = 1'b0;
                dAddr = {$urandom, $urandom}; dWdata = {$urandom, $urandom};
            end
            applyStimulus($urandom_range(0, 2), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
            checkOutput("grantOrder", 64'(lastGrantD), 64'(expectD[i]));
        end
        ifPending = 1'b0;
        dPending  = 1'b0;

        $display("[TB] timeout then normal access");
        dPending = 1'b1; dWe = 1'b0; dAddr = 64'h200;
        applyStimulus(TIMEOUT + 5, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0);
        dPending = 1'b1; dWe = 1'b0; dAddr = 64'h208;
        applyStimulus(2, 64'hA5A5_0000_FFFF_5A5A, 1'b0, 1'b0, 1'b0);
        dPending = 1'b1; dWe = 1'b0; dAddr = 64'h210;
        applyStimulus(TIMEOUT - 1, 64'h7777_8888_9999_AAAA, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-access");
        dPending = 1'b1; dWe = 1'b0; dAddr = 64'h300;
        applyStimulus(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0, 1'b0);

        $display("[TB] store with stray ready");
        dPending = 1'b1; dWe = 1'b1; dAddr = 64'h8; dWdata = 64'h55;
        applyStimulus(2, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 150; i++) begin
            refillRequests(60, 70);
            pick = $urandom_range(0, 9);
            if (pick < 7)      latency = $urandom_range(0, 4);
            else if (pick < 9) latency = $urandom_range(5, TIMEOUT - 1);
            else               latency = TIMEOUT + 3;
            applyStimulus(latency, {$urandom, $urandom},
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-ported 64-bit unified memory shared by the pipeline's instruction-fetch requester (IF) and its MEM-stage data requester. It sits between the PC/IF stage and the MEM stage on one side and the memory macro on the other. It allows one outstanding access at a time and gives priority to data with a starvation guard for fetch. It drives per-requester stall and valid signals so the hazard logic can freeze the PC and the pipeline registers.

## Interface
- STARVE_MAX, 4: consecutive lost arbitrations after which fetch wins; must be ≥1.
- TIMEOUT, 16: maximum WAIT cycles without mem_ready before abort; must be ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  64  fetch byte address, 4-byte aligned.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle response pulse.
- if_stall  out  1  = if_req & ~if_valid (combinational).
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_rdata  out  64  load data.
- d_valid  out  1  one-cycle response pulse.
- d_stall  out  1  = d_req & ~d_valid (combinational).
- err  out  1  timeout flag; pulses together with the aborted requester's valid.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  memory address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completion strobe.

## Operation
- FSM states: IDLE, IF_WAIT, D_WAIT, RESP.
- IDLE, arbitration:
  - Only d_req: grant data → D_WAIT.
  - Only if_req: grant fetch → IF_WAIT.
  - Both, with starve_cnt < STARVE_MAX: grant data.
  - Both, with starve_cnt == STARVE_MAX: grant fetch.
  - Neither: stay in IDLE.
- On grant, register mem_addr, mem_we and mem_wdata, plus the served requester's identity.
  - Fetch grant: mem_addr = {if_addr[63:3],3'b000}, mem_we=0, and latch if_addr[2].
  - Data grant: mem_addr = d_addr, mem_we = d_we, mem_wdata = d_wdata.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each data grant while if_req=1.
  - Clears to 0 on every fetch grant.
- WAIT states:
  - mem_en=1; mem_addr, mem_we and mem_wdata are held stable.
  - wait_cnt increments each cycle.
  - mem_ready=1 → capture the response, go to RESP.
  - wait_cnt reaching TIMEOUT-1 without mem_ready → go to RESP with the error flag set.
  - mem_ready has priority over timeout in the same cycle.
- Response capture:
  - Fetch: if_rdata = latched bit2 ? mem_rdata[63:32] : mem_rdata[31:0].
  - Data load: d_rdata = mem_rdata.
  - Data store: d_rdata is unchanged.
  - Timeout: the read-data register is loaded with 0.
- RESP:
  - mem_en=0.
  - The served requester's valid=1, and err=1 if the transaction timed out.
  - Unconditional transition → IDLE; there is no grant in RESP.
- mem_ready outside the WAIT states is ignored.
- A requester dropping req during WAIT does not abort the access; valid still pulses in RESP.
- Reset (rst_n=0 at a clock edge), at any time including mid-transaction:
  - State → IDLE.
  - mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_valid, d_valid, err, starve_cnt and wait_cnt → 0.
  - The in-flight access is dropped; no valid pulse is issued for it.

## Timing
- All outputs are registered except if_stall and d_stall.
- Minimum access: req seen in IDLE at edge N → mem_en=1 in cycle N+1 → mem_ready in N+1 → valid/rdata in N+2 (RESP) → IDLE in N+3.
- Back-to-back throughput: one access per 3 cycles minimum.
- Timeout: with no mem_ready, mem_en stays high for exactly TIMEOUT cycles, then RESP with err=1.
- Requesters must change or drop req at the edge ending their RESP cycle.

## Test plan
- Single load: reset, then d_req=1, d_we=0, d_addr=0x40; memory returns 0xDEADBEEF_CAFEF00D with ready 1 cycle after mem_en. Required: d_valid pulse 2 cycles after grant, with d_rdata=0xDEADBEEF_CAFEF00D, d_stall=1 until that cycle, and err=0.
- Fetch halves: if_addr=0x104 with memory word 0x11111111_22222222 at 0x100. Required: mem_addr=0x100 and if_rdata=0x11111111. Then if_addr=0x100 → if_rdata=0x22222222.
- Contention/starvation (STARVE_MAX=4): if_req and d_req held high continuously. Required grant sequence D,D,D,D,I,D,D,D,D,I, with starve_cnt clearing on each I.
- Timeout (TIMEOUT=16): d_req with mem_ready held low. Required: mem_en high exactly 16 cycles, then d_valid=1, err=1, d_rdata=0. Then IDLE, and the next request is served normally.
- Reset mid-access: assert rst_n=0 during D_WAIT, with mem_ready=1 in the same cycle. Required: next cycle mem_en=0, d_valid=0, all outputs 0. After release, a held d_req is re-granted from IDLE.
- Store plus stray ready: d_we=1, d_wdata=0x55, d_addr=0x8, with mem_ready pulsed while in IDLE beforehand. Required: the stray pulse is ignored, mem_we=1 and mem_wdata=0x55 through the WAIT state, d_valid pulses once, and d_rdata is unchanged.
